// File: rtl/naive_ntt_pkg.sv
// Shared definitions for the naive forward/inverse 8-point NTT blocks:
// sizes, the inverse-NTT state encoding and lane pack/unpack helpers.
package naive_ntt_pkg;

    localparam int N = 8;
    localparam int W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TWID  = 3'd1,
        S_MAC   = 3'd2,
        S_SCALE = 3'd3,
        S_DONE  = 3'd4
    } intt_state_t;

    function automatic logic [W-1:0] get_lane(input logic [N*W-1:0] vec, input logic [2:0] idx);
        return vec[int'(idx)*W +: W];
    endfunction

    function automatic logic [N*W-1:0] put_lane(input logic [N*W-1:0] vec, input logic [2:0] idx,
                                                input logic [W-1:0] val);
        logic [N*W-1:0] r_vec;
        r_vec = vec;
        r_vec[int'(idx)*W +: W] = val;
        return r_vec;
    endfunction

endpackage

// File: rtl/naive_intt_mod_mac.sv
// Combinational modular multiply-accumulate r = (a + b*c) % m, with m == 0
// forced to a zero result so a degenerate modulus never produces X.
module mod_mac #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    input  logic [W-1:0] i_m,
    output logic [W-1:0] o_r
);

    logic [2*W-1:0] w_prod;
    logic [2*W:0]   w_sum;

    assign w_prod = {{W{1'b0}}, i_b} * {{W{1'b0}}, i_c};
    assign w_sum  = {1'b0, w_prod} + {{(W+1){1'b0}}, i_a};

    always_comb begin
        o_r = '0;
        if (i_m != '0) begin
            o_r = W'(w_sum % {{(W+1){1'b0}}, i_m});
        end
    end

endmodule

// File: rtl/naive_intt.sv
// Sequential inverse 8-point NTT: one shared mod_mac builds the twiddle table,
// accumulates each output row and applies the n_inv scaling.
module naive_intt #(
    parameter int N = 8,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] data_in,
    input  logic [W-1:0]   omega_inv,
    input  logic [W-1:0]   n_inv,
    input  logic [W-1:0]   mod,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] data_out,
    output logic           busy
);
    import naive_ntt_pkg::*;

    intt_state_t r_state;
    intt_state_t w_state_next;

    logic [W-1:0] r_x  [N];
    logic [W-1:0] r_tw [N];
    logic [W-1:0] r_y  [N];
    logic [W-1:0] r_omega;
    logic [W-1:0] r_ninv;
    logic [W-1:0] r_mod;
    logic [W-1:0] r_acc;
    logic [2:0]   r_k;
    logic [2:0]   r_i;
    logic [2:0]   r_j;

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W-1:0] w_c;
    logic [W-1:0] w_r;
    logic [2:0]   w_exp;

    // Exponent i*j reduced mod 8 by keeping only the low three bits.
    assign w_exp = r_i * r_j;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = S_TWID;
            end
            S_TWID: begin
                busy = 1'b1;
                if (r_k == 3'd7) w_state_next = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (r_j == 3'd7) w_state_next = S_SCALE;
            end
            S_SCALE: begin
                busy = 1'b1;
                w_state_next = (r_i == 3'd7) ? S_DONE : S_MAC;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The single mod_mac is time-shared; operands are steered by state.
    always_comb begin
        w_a = '0;
        w_b = '0;
        w_c = '0;
        case (r_state)
            S_TWID: begin
                if (r_k == 3'd0) begin
                    w_b = W'(1);
                    w_c = W'(1);
                end else begin
                    w_b = r_tw[r_k - 3'd1];
                    w_c = r_omega;
                end
            end
            S_MAC: begin
                w_a = r_acc;
                w_b = r_x[r_j];
                w_c = r_tw[w_exp];
            end
            S_SCALE: begin
                w_b = r_acc;
                w_c = r_ninv;
            end
            default: ;
        endcase
    end

    mod_mac #(.W(W)) u_mod_mac (
        .i_a (w_a),
        .i_b (w_b),
        .i_c (w_c),
        .i_m (r_mod),
        .o_r (w_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N; n++) begin
                r_x[n]  <= '0;
                r_tw[n] <= '0;
                r_y[n]  <= '0;
            end
            r_omega <= '0;
            r_ninv  <= '0;
            r_mod   <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_i     <= '0;
            r_j     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int n = 0; n < N; n++) begin
                            r_x[n] <= get_lane(data_in, 3'(n));
                        end
                        r_omega <= omega_inv;
                        r_ninv  <= n_inv;
                        r_mod   <= mod;
                        r_k     <= '0;
                    end
                end
                S_TWID: begin
                    r_tw[r_k] <= w_r;
                    r_k       <= r_k + 3'd1;
                    if (r_k == 3'd7) begin
                        r_i   <= '0;
                        r_j   <= '0;
                        r_acc <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= w_r;
                    r_j   <= r_j + 3'd1;
                end
                S_SCALE: begin
                    r_y[r_i] <= w_r;
                    r_acc    <= '0;
                    r_j      <= '0;
                    if (r_i != 3'd7) r_i <= r_i + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Result is only presented in DONE, so intermediate rows never leak out.
    always_comb begin
        data_out = '0;
        if (r_state == S_DONE) begin
            for (int n = 0; n < N; n++) begin
                data_out = put_lane(data_out, 3'(n), r_y[n]);
            end
        end
    end

endmodule

// File: tb/tb_naive_intt.sv
// Directed self-checking bench for naive_intt: known transforms, latency,
// backpressure, mid-job reset and degenerate moduli.
module tb_naive_intt;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_in;
    logic [7:0]  omega_inv;
    logic [7:0]  n_inv;
    logic [7:0]  mod;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;
    logic        busy;

    int checkCount = 0;
    int passCount  = 0;

    naive_intt #(.N(8), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .omega_inv (omega_inv),
        .n_inv     (n_inv),
        .mod       (mod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference forward NTT used only to build the round-trip stimulus.
    function automatic logic [63:0] forwardNtt(input logic [63:0] x, input int m, input int om);
        int tw [8];
        int acc;
        logic [63:0] res;
        tw[0] = 1 % m;
        for (int t = 1; t < 8; t++) tw[t] = (tw[t-1] * om) % m;
        res = '0;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int j = 0; j < 8; j++) begin
                acc = (acc + int'(x[8*j +: 8]) * tw[(j*k) % 8]) % m;
            end
            res[8*k +: 8] = 8'(acc);
        end
        return res;
    endfunction

    task automatic applyStimulus(input logic [63:0] din, input logic [7:0] om, input logic [7:0] ninv,
                                 input logic [7:0] md, output logic [63:0] res, output int lat);
        @(negedge clk);
        data_in   = din;
        omega_inv = om;
        n_inv     = ninv;
        mod       = md;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        data_in   = 64'hDEAD_BEEF_CAFE_F00D;
        omega_inv = 8'hA5;
        n_inv     = 8'h3C;
        mod       = 8'hFB;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        res = data_out;
    endtask

    task automatic completeHandshake(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_inReadyAfterAck"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_outValidAfterAck"}, 64'(out_valid), 64'd0);
    endtask

    task automatic runJob(input string tag, input logic [63:0] din, input logic [7:0] om,
                          input logic [7:0] ninv, input logic [7:0] md, input logic [63:0] exp);
        logic [63:0] res;
        int lat;
        applyStimulus(din, om, ninv, md, res, lat);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd80);
        checkOutput({tag, "_data"}, res, exp);
        checkOutput({tag, "_busyInDone"}, 64'(busy), 64'd0);
        completeHandshake(tag);
    endtask

    initial begin
        logic [63:0] res;
        int lat;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        omega_inv = '0;
        n_inv     = '0;
        mod       = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_inReady", 64'(in_ready), 64'd1);
        checkOutput("reset_outValid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_dataOut", data_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runJob("impulse", 64'h0000_0000_0000_0001, 8'd9, 8'd15, 8'd17, 64'h0F0F_0F0F_0F0F_0F0F);
        runJob("allOnes", 64'h0101_0101_0101_0101, 8'd9, 8'd15, 8'd17, 64'h0000_0000_0000_0001);
        runJob("deltaJ1", 64'h0000_0000_0000_0100, 8'd9, 8'd15, 8'd17, 64'h0D09_0102_0408_100F);
        runJob("inputAboveMod", 64'h0000_0000_0000_0012, 8'd9, 8'd15, 8'd17, 64'h0F0F_0F0F_0F0F_0F0F);
        runJob("roundTrip", forwardNtt(64'h0807_0605_0403_0201, 17, 2), 8'd9, 8'd15, 8'd17,
               64'h0807_0605_0403_0201);

        // Backpressure: hold the result and poke in_valid while DONE.
        applyStimulus(64'h0000_0000_0000_0001, 8'd9, 8'd15, 8'd17, res, lat);
        checkOutput("bp_latency", 64'(lat), 64'd80);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = (c == 4);
            data_in  = 64'h1111_1111_1111_1111;
            mod      = 8'd17;
            @(posedge clk);
            #1;
            checkOutput("bp_dataStable", data_out, 64'h0F0F_0F0F_0F0F_0F0F);
            checkOutput("bp_inReadyLow", 64'(in_ready), 64'd0);
            checkOutput("bp_outValidHeld", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        completeHandshake("bp");
        @(posedge clk);
        #1;
        checkOutput("bp_pulseIgnored", 64'(busy), 64'd0);

        // Reset in the middle of MAC row 3.
        @(negedge clk);
        data_in   = 64'h0000_0000_0000_0001;
        omega_inv = 8'd9;
        n_inv     = 8'd15;
        mod       = 8'd17;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("rst_busyMidJob", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_inReady", 64'(in_ready), 64'd1);
        checkOutput("rst_outValid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_dataOut", data_out, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runJob("afterReset", 64'h0101_0101_0101_0101, 8'd9, 8'd15, 8'd17, 64'h0000_0000_0000_0001);

        runJob("mod0", 64'h0123_4567_89AB_CDEF, 8'd9, 8'd15, 8'd0, 64'd0);
        runJob("mod1", 64'hFEDC_BA98_7654_3210, 8'd9, 8'd15, 8'd1, 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
